// File: rtl/strip_transition_scheduler.sv
// strip_transition_scheduler
//
// Counts the vertical 0/1 transitions in each column of a binary image frame. The frame is
// read from the image buffer one row per cycle. Each row is XORed with the previous row, and
// the result is accumulated into one counter per column. The column counts are then streamed
// out one at a time over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   start             frame request, sampled only while idle
//   busy, done        busy in every state except IDLE; done is a one-cycle pulse after the last
//                     count has been accepted
//   mem_rd_en         image buffer read strobe
//   mem_addr          image buffer row address
//   mem_rdata         image buffer row data, returned one cycle after the read
//   feat_valid        feature stream valid
//   feat_ready        feature stream ready
//   feat_col          column index of the current count
//   feat_count        transition count for that column
//   frame_total       sum of all accepted column counts
module strip_transition_scheduler #(
    parameter int unsigned ROWS   = 28,
    parameter int unsigned COLS   = 28,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 5,
    parameter int unsigned COL_W  = 5,
    parameter int unsigned TOT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [COLS-1:0]   mem_rdata,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic [COL_W-1:0]  feat_col,
    output logic [CNT_W-1:0]  feat_count,
    output logic [TOT_W-1:0]  frame_total
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    // A read was issued last cycle, so mem_rdata carries row data in this cycle.
    logic              rd_q, rd_d;
    // The row being returned is row 0: it only seeds prev and is not counted.
    logic              first_q, first_d;
    logic [COLS-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q [COLS];
    logic [CNT_W-1:0]  cnt_d [COLS];
    logic [COL_W-1:0]  col_q, col_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic              handshake;

    assign handshake = (state_q == EMIT) && feat_ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        prev_d  = prev_q;
        col_d   = col_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        rd_d    = (state_q == READ);
        first_d = (state_q == READ) && (row_q == '0);

        // Capture runs in whichever cycle returns data (READ or DRAIN).
        if (rd_q) begin
            prev_d = mem_rdata;
            if (!first_q) begin
                for (int c = 0; c < int'(COLS); c++) begin
                    cnt_d[c] = cnt_q[c] + {{(CNT_W-1){1'b0}}, prev_q[c] ^ mem_rdata[c]};
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    row_d   = '0;
                    col_d   = '0;
                    total_d = '0;
                    for (int c = 0; c < int'(COLS); c++) begin
                        cnt_d[c] = '0;
                    end
                end
            end
            READ: begin
                if (row_q == ADDR_W'(ROWS - 1)) begin
                    state_d = DRAIN;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DRAIN: state_d = EMIT;
            EMIT: begin
                if (handshake) begin
                    total_d = total_q + TOT_W'(cnt_q[col_q]);
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_d = DONE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                col_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            rd_q    <= 1'b0;
            first_q <= 1'b0;
            prev_q  <= '0;
            col_q   <= '0;
            total_q <= '0;
            for (int c = 0; c < int'(COLS); c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rd_q    <= rd_d;
            first_q <= first_d;
            prev_q  <= prev_d;
            col_q   <= col_d;
            total_q <= total_d;
            for (int c = 0; c < int'(COLS); c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // Outputs are decoded from registered state, so an asynchronous reset clears them at once.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        mem_rd_en   = (state_q == READ);
        mem_addr    = (state_q == READ) ? row_q : '0;
        feat_valid  = (state_q == EMIT);
        feat_count  = (state_q == EMIT) ? cnt_q[col_q] : '0;
        feat_col    = col_q;
        frame_total = total_q;
    end

endmodule

// File: tb/tb_strip_transition_scheduler.sv
module tb_strip_transition_scheduler;

    localparam int unsigned ROWS   = 28;
    localparam int unsigned COLS   = 28;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned COL_W  = 5;
    localparam int unsigned TOT_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [COLS-1:0]   mem_rdata;
    logic              feat_valid;
    logic              feat_ready;
    logic [COL_W-1:0]  feat_col;
    logic [CNT_W-1:0]  feat_count;
    logic [TOT_W-1:0]  frame_total;

    strip_transition_scheduler #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .COL_W  (COL_W),
        .TOT_W  (TOT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .feat_valid  (feat_valid),
        .feat_ready  (feat_ready),
        .feat_col    (feat_col),
        .feat_count  (feat_count),
        .frame_total (frame_total)
    );

    always #5 clk = ~clk;

    logic [COLS-1:0]   img [ROWS];
    int                exp_cnt [COLS];
    int                exp_total;
    int                n_checks;
    int                n_fail;
    int                cyc;
    logic              prev_rd;
    logic [ADDR_W-1:0] prev_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: count value changes down each column of the image.
    task automatic compute_model();
        exp_total = 0;
        for (int c = 0; c < int'(COLS); c++) begin
            exp_cnt[c] = 0;
            for (int r = 1; r < int'(ROWS); r++) begin
                if (img[r][c] != img[r-1][c]) exp_cnt[c]++;
            end
            exp_total += exp_cnt[c];
        end
    endtask

    // Advance one cycle; the image buffer returns the row read in the previous cycle and
    // drives garbage otherwise.
    task automatic tick();
        prev_rd   = mem_rd_en;
        prev_addr = mem_addr;
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = prev_rd ? img[prev_addr] : COLS'($urandom);
    endtask

    task automatic run_frame(input string name, input bit rand_ready, input bit poke);
        int               hs;
        int               rd_cnt;
        int               done_cnt;
        int               first_valid;
        int               done_cyc;
        bit               stalled;
        logic [COL_W-1:0] st_col;
        logic [CNT_W-1:0] st_cnt;
        logic [TOT_W-1:0] tot_at_done;
        compute_model();
        hs = 0; rd_cnt = 0; done_cnt = 0; first_valid = -1; done_cyc = -1; stalled = 1'b0;
        st_col = '0; st_cnt = '0; tot_at_done = '0;
        check({name, " idle before start"}, 32'(busy), 32'd0);
        cyc        = 0;
        start      = 1'b1;
        feat_ready = 1'b0;
        while (done_cyc < 0 && cyc < 400) begin
            tick();
            start      = poke && (cyc == 5 || cyc == 35);
            feat_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check({name, " busy"}, 32'(busy), 32'd1);
            if (stalled) begin
                check({name, " stall valid"}, 32'(feat_valid), 32'd1);
                check({name, " stall col"}, 32'(feat_col), 32'(st_col));
                check({name, " stall count"}, 32'(feat_count), 32'(st_cnt));
            end
            if (mem_rd_en) begin
                check({name, " read addr"}, 32'(mem_addr), rd_cnt);
                check({name, " read cycle"}, cyc, rd_cnt + 1);
                rd_cnt++;
            end
            if (feat_valid && first_valid < 0) first_valid = cyc;
            if (feat_valid && feat_ready) begin
                check({name, " col order"}, 32'(feat_col), hs);
                check({name, " count"}, 32'(feat_count), (hs < int'(COLS)) ? exp_cnt[hs] : -1);
                hs++;
            end
            stalled = feat_valid && !feat_ready;
            st_col  = feat_col;
            st_cnt  = feat_count;
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
                tot_at_done = frame_total;
                check({name, " valid low in done"}, 32'(feat_valid), 32'd0);
            end
        end
        check({name, " done seen"}, 32'(done_cyc >= 0), 32'd1);
        check({name, " reads"}, rd_cnt, ROWS);
        check({name, " handshakes"}, hs, COLS);
        check({name, " first valid cycle"}, first_valid, ROWS + 2);
        if (!rand_ready) check({name, " done cycle"}, done_cyc, ROWS + 2 + COLS);
        check({name, " total at done"}, 32'(tot_at_done), exp_total);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({name, " done once"}, 32'(done), 32'd0);
            check({name, " idle after"}, 32'(busy), 32'd0);
            check({name, " col reset"}, 32'(feat_col), 32'd0);
            check({name, " total stable"}, 32'(frame_total), exp_total);
        end
        check({name, " single done"}, done_cnt, 1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        feat_ready = 1'b0;
        mem_rdata  = '0;
        for (int r = 0; r < int'(ROWS); r++) img[r] = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rd_en", 32'(mem_rd_en), 32'd0);
        check("reset addr", 32'(mem_addr), 32'd0);
        check("reset valid", 32'(feat_valid), 32'd0);
        check("reset col", 32'(feat_col), 32'd0);
        check("reset count", 32'(feat_count), 32'd0);
        check("reset total", 32'(frame_total), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        run_frame("zero", 1'b0, 1'b0);

        for (int r = 0; r < int'(ROWS); r++) img[r] = (r % 2 == 0) ? '1 : '0;
        run_frame("alternating", 1'b0, 1'b0);
        check("alternating total 756", 32'(frame_total), 32'd756);

        for (int r = 0; r < int'(ROWS); r++) begin
            img[r]    = '0;
            img[r][3] = ((r / 2) % 2 == 0);
        end
        run_frame("column3", 1'b0, 1'b0);
        check("column3 total 13", 32'(frame_total), 32'd13);

        for (int r = 0; r < int'(ROWS); r++) img[r] = COLS'($urandom);
        run_frame("backpressure", 1'b1, 1'b0);

        for (int r = 0; r < int'(ROWS); r++) img[r] = COLS'($urandom);
        run_frame("start poke", 1'b0, 1'b1);

        // Abort a frame at row 10, then rerun it cleanly.
        for (int r = 0; r < int'(ROWS); r++) img[r] = COLS'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !(mem_rd_en && mem_addr == ADDR_W'(10)); i++) tick();
        check("reached row 10", 32'(mem_rd_en && mem_addr == ADDR_W'(10)), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst rd_en", 32'(mem_rd_en), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst valid", 32'(feat_valid), 32'd0);
        check("async rst total", 32'(frame_total), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("no restart after reset", 32'(busy), 32'd0);
        run_frame("after reset", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
